pe_cmp_exchange: RTL
====================

# pe_cmp_exchange

Parametrised neighbour compare-exchange stage for the Nanci mesh-sort processing element. It holds one local record {addr, data}, broadcasts it to the four mesh neighbours, and on each step command samples one selected neighbour (left/right/up/down). Depending on the step mode it keeps the min or max key, copies the neighbour unconditionally, or holds. It replaces the fixed-selection PE datapath with a run-time-commanded, width-generic, multi-cycle-settling unit that has a start/done handshake and swap statistics.

## Interface
- ADDR_WIDTH, 3, key field width; upper bits of a record.
- DATA_WIDTH, 3, payload width; lower bits of a record.
- CYCLES_PER_STEP, 1, wait cycles from step acceptance to sampling, counted from the acceptance edge; legal values ≥1.
- SWAP_CNT_WIDTH, 8, width of the saturating swap counter.
- W denotes ADDR_WIDTH+DATA_WIDTH.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_init_valid  in  1  load the local record from i_init.
- i_init  in  W  initial record {addr, data}.
- i_step_valid  in  1  step command strobe.
- i_step_dir  in  2  neighbour select: 0=l, 1=r, 2=u, 3=d.
- i_step_mode  in  2  0=keep-min, 1=keep-max, 2=copy, 3=hold.
- i_PE_l, i_PE_r, i_PE_u, i_PE_d  in  W each  neighbour records.
- o_PE  out  W  local record, registered and driven continuously.
- o_busy  out  1  step in progress.
- o_done  out  1  one-cycle pulse after a step completes.
- o_swap_cnt  out  SWAP_CNT_WIDTH  count of steps that replaced the local record; saturates at all-ones.

## Operation
- FSM states: IDLE and WAIT.
- IDLE:
  - If i_init_valid is high, load o_PE from i_init and ignore i_step_valid that cycle. Init has priority.
  - Otherwise, if i_step_valid is high, latch dir and mode, load the counter with CYCLES_PER_STEP-1, and go to WAIT.
- WAIT:
  - Neighbour inputs are not sampled while the counter is nonzero. The counter decrements each cycle.
  - When the counter is 0, sample the selected neighbour record N and compare unsigned N[W-1:DATA_WIDTH] against the local key.
  - keep-min: replace if N.key < local.key.
  - keep-max: replace if N.key > local.key.
  - copy: always replace.
  - hold: never replace.
  - Equal keys never replace in min or max mode. Data bits take no part in the comparison.
  - On replacement, o_PE <= N and o_swap_cnt increments, saturating at all-ones. A copy always counts, even when N equals the local record.
  - Return to IDLE and set o_done for one cycle.
- i_step_valid and i_init_valid are ignored while in WAIT. No queueing.
- The dir and mode latched at acceptance are used. Input changes during WAIT have no effect on them.
- Reset:
  - o_PE=0, o_busy=0, o_done=0, o_swap_cnt=0, state IDLE, counter 0.
  - A reset asserted during WAIT aborts the step with no exchange and no done pulse.

## Timing
- Step accepted at edge k: o_busy=1 from after edge k.
- The exchange occurs at edge k+CYCLES_PER_STEP.
  - o_PE takes the new value after that edge.
  - o_busy=0 and o_done=1 for exactly the following cycle.
- Back-to-back steps: a new step may be accepted on the edge that ends the o_done cycle. Step throughput is one per CYCLES_PER_STEP+1 cycles.
- o_PE changes only at a reset, init, or exchange edge. Neighbours see o_PE with zero added combinational delay.
- Init is accepted in IDLE; o_PE is updated on the next edge.

## Test plan
All scenarios use ADDR_WIDTH=3 and DATA_WIDTH=3, with neighbours l=001000, r=010000, u=011000, d=100000.

- **Reset hold:** rst=1 for 2 cycles → o_PE=000000, o_busy=0, o_done=0, o_swap_cnt=0.
- **Copy down:** init 000111, then step dir=3, mode=copy, CYCLES_PER_STEP=1 → o_PE=100000 one edge after acceptance, o_done pulses once, o_swap_cnt=1.
- **Min and max with ties:**
  - Init 011101, step dir=0, mode=min → o_PE=001000.
  - Step dir=2, mode=max (key 3 vs 1) → o_PE=011000.
  - Step dir=2, mode=max again (equal keys) → o_PE unchanged, o_swap_cnt=2.
- **Ignore while busy:** CYCLES_PER_STEP=4; assert a second step and an init during WAIT → only the first step executes, o_done pulses once, exactly 4 cycles after acceptance.
- **Reset mid-step:** assert rst during WAIT → no o_done, o_PE=000000, o_swap_cnt=0. A subsequent step executes normally.
- **Saturation:** SWAP_CNT_WIDTH=2; issue 5 copy steps → o_swap_cnt=3.

Source files
------------

// File: rtl/pe_cmp_exchange.sv
// pe_cmp_exchange: mesh-sort PE stage that compare-exchanges its record with one commanded neighbour
module pe_cmp_exchange #(
    parameter int ADDR_WIDTH      = 3,
    parameter int DATA_WIDTH      = 3,
    parameter int CYCLES_PER_STEP = 1,
    parameter int SWAP_CNT_WIDTH  = 8,
    parameter int W               = ADDR_WIDTH + DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_init_valid,
    input  logic [W-1:0]              i_init,
    input  logic                      i_step_valid,
    input  logic [1:0]                i_step_dir,
    input  logic [1:0]                i_step_mode,
    input  logic [W-1:0]              i_PE_l,
    input  logic [W-1:0]              i_PE_r,
    input  logic [W-1:0]              i_PE_u,
    input  logic [W-1:0]              i_PE_d,
    output logic [W-1:0]              o_PE,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [SWAP_CNT_WIDTH-1:0] o_swap_cnt
);
    localparam int CW = $clog2(CYCLES_PER_STEP) + 1;
    typedef enum logic {IDLE, WAIT} state_t;
    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [1:0]                dir_q, dir_d, mode_q, mode_d;
    logic [W-1:0]              pe_q, pe_d, nbr;
    logic                      done_q, done_d, replace;
    logic [SWAP_CNT_WIDTH-1:0] swap_q, swap_d;
    logic [ADDR_WIDTH-1:0]     nkey, lkey;

    // neighbour mux, key compare and step sequencing; the latched dir/mode isolate the step from input changes
    always_comb begin
        nbr     = dir_q == 2'd0 ? i_PE_l : dir_q == 2'd1 ? i_PE_r : dir_q == 2'd2 ? i_PE_u : i_PE_d;
        nkey    = nbr[W-1:DATA_WIDTH];
        lkey    = pe_q[W-1:DATA_WIDTH];
        replace = mode_q == 2'd2 || (mode_q == 2'd0 && nkey < lkey) || (mode_q == 2'd1 && nkey > lkey);
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        pe_d    = pe_q;
        done_d  = 1'b0;
        swap_d  = swap_q;
        if (state_q == IDLE) begin
            if (i_init_valid) begin
                pe_d = i_init;
            end else if (i_step_valid) begin
                dir_d   = i_step_dir;
                mode_d  = i_step_mode;
                cnt_d   = CW'(CYCLES_PER_STEP - 1);
                state_d = WAIT;
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (replace) begin
                pe_d   = nbr;
                swap_d = &swap_q ? swap_q : swap_q + SWAP_CNT_WIDTH'(1);
            end
        end
    end

    // state registers; reset aborts any step in flight without an exchange or done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= '0;
            mode_q  <= '0;
            pe_q    <= '0;
            done_q  <= 1'b0;
            swap_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            pe_q    <= pe_d;
            done_q  <= done_d;
            swap_q  <= swap_d;
        end
    end

    assign o_PE       = pe_q;
    assign o_busy     = state_q == WAIT;
    assign o_done     = done_q;
    assign o_swap_cnt = swap_q;
endmodule
